// File: rtl/spi_cmd_regfile.sv
// rtl/spi_cmd_regfile.sv - byte-level SPI command decoder with parameter registers and feedback readback
module spi_cmd_regfile #(
    parameter int                NUM_REGS = 4,
    parameter int                NUM_FB   = 2,
    parameter int                DATA_W   = 16,
    parameter int                CHK_EN   = 1,
    parameter logic [DATA_W-1:0] REG_RST  = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [7:0]                 rx_data,
    input  logic                       rx_valid,
    input  logic                       cs_n,
    output logic [7:0]                 tx_data,
    output logic                       machine_start,
    output logic                       machine_stop,
    output logic [NUM_REGS*DATA_W-1:0] reg_data,
    output logic [NUM_REGS-1:0]        reg_update,
    input  logic [NUM_FB*DATA_W-1:0]   fb_data,
    output logic                       cmd_err
);

    localparam int            NB   = DATA_W / 8;
    localparam int            CW   = $clog2(NB) + 1;
    localparam logic [CW-1:0] LAST = CW'(NB - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PULSE_START,
        S_PULSE_STOP,
        S_WR_DATA,
        S_WR_CHK,
        S_RD_DATA
    } state_t;

    state_t                     state_q;
    logic [CW-1:0]              cnt_q;
    logic [3:0]                 idx_q;
    logic [7:0]                 acc_q;
    logic [DATA_W-1:0]          shadow_q;
    logic [NUM_REGS*DATA_W-1:0] reg_q;
    logic [NUM_REGS-1:0]        upd_q;
    logic                       start_q;
    logic                       stop_q;
    logic                       err_q;
    logic [7:0]                 tx_q;
    logic                       cs_meta_q;
    logic                       cs_sync_q;
    logic                       cs_prev_q;

    logic                       frame_end;
    logic                       op_wr;
    logic                       op_rd;
    logic [CW-1:0]              cnt_inc;
    logic [DATA_W-1:0]          shadow_d;
    logic [DATA_W-1:0]          commit_src;
    logic [7:0]                 rd_next;
    logic [DATA_W-1:0]          fb_sel;
    logic [NUM_REGS*DATA_W-1:0] reg_d;
    logic [NUM_REGS-1:0]        upd_d;

    // Bring chip select into the clk domain; a rising edge marks the end of a frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_meta_q <= 1'b1;
            cs_sync_q <= 1'b1;
            cs_prev_q <= 1'b1;
        end else begin
            cs_meta_q <= cs_n;
            cs_sync_q <= cs_meta_q;
            cs_prev_q <= cs_sync_q;
        end
    end

    assign frame_end = cs_sync_q & ~cs_prev_q;
    assign op_wr     = (rx_data[7:4] == 4'h8) && (int'(rx_data[3:0]) < NUM_REGS);
    assign op_rd     = (rx_data[7:4] == 4'hC) && (int'(rx_data[3:0]) < NUM_FB);
    assign cnt_inc   = cnt_q + CW'(1);

    // Byte-lane helpers: merge the incoming byte, pick the next readback byte, select the feedback channel.
    always_comb begin
        shadow_d = shadow_q;
        rd_next  = 8'hFF;
        fb_sel   = '0;
        for (int b = 0; b < NB; b++) begin
            if (cnt_q == CW'(b)) begin
                shadow_d[b*8 +: 8] = rx_data;
            end
            if (cnt_inc == CW'(b)) begin
                rd_next = shadow_q[b*8 +: 8];
            end
        end
        for (int ch = 0; ch < NUM_FB; ch++) begin
            if (rx_data[3:0] == 4'(ch)) begin
                fb_sel = fb_data[ch*DATA_W +: DATA_W];
            end
        end
    end

    // Whole-register commit value: the target register is replaced in a single cycle.
    always_comb begin
        commit_src = (state_q == S_WR_CHK) ? shadow_q : shadow_d;
        reg_d      = reg_q;
        upd_d      = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (idx_q == 4'(r)) begin
                reg_d[r*DATA_W +: DATA_W] = commit_src;
                upd_d[r]                  = 1'b1;
            end
        end
    end

    // Command FSM with registered pulses and response byte; frame end overrides after the byte is handled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            acc_q    <= '0;
            shadow_q <= '0;
            reg_q    <= {NUM_REGS{REG_RST}};
            upd_q    <= '0;
            start_q  <= 1'b0;
            stop_q   <= 1'b0;
            err_q    <= 1'b0;
            tx_q     <= 8'hFF;
        end else begin
            start_q <= 1'b0;
            stop_q  <= 1'b0;
            err_q   <= 1'b0;
            upd_q   <= '0;
            case (state_q)
                S_IDLE: begin
                    if (rx_valid) begin
                        if (rx_data == 8'h06) begin
                            start_q <= 1'b1;
                            state_q <= S_PULSE_START;
                        end else if (rx_data == 8'h04) begin
                            stop_q  <= 1'b1;
                            state_q <= S_PULSE_STOP;
                        end else if (op_wr) begin
                            idx_q    <= rx_data[3:0];
                            cnt_q    <= '0;
                            acc_q    <= rx_data;
                            shadow_q <= '0;
                            state_q  <= S_WR_DATA;
                        end else if (op_rd) begin
                            idx_q    <= rx_data[3:0];
                            cnt_q    <= '0;
                            shadow_q <= fb_sel;
                            tx_q     <= fb_sel[7:0];
                            state_q  <= S_RD_DATA;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                S_PULSE_START, S_PULSE_STOP: begin
                    state_q <= S_IDLE;
                end
                S_WR_DATA: begin
                    if (rx_valid) begin
                        shadow_q <= shadow_d;
                        acc_q    <= acc_q ^ rx_data;
                        if (cnt_q == LAST) begin
                            cnt_q <= '0;
                            if (CHK_EN != 0) begin
                                state_q <= S_WR_CHK;
                            end else begin
                                reg_q    <= reg_d;
                                upd_q    <= upd_d;
                                shadow_q <= '0;
                                state_q  <= S_IDLE;
                            end
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end
                end
                S_WR_CHK: begin
                    if (rx_valid) begin
                        if (rx_data == acc_q) begin
                            reg_q <= reg_d;
                            upd_q <= upd_d;
                        end else begin
                            err_q <= 1'b1;
                        end
                        shadow_q <= '0;
                        state_q  <= S_IDLE;
                    end
                end
                S_RD_DATA: begin
                    if (rx_valid) begin
                        if (cnt_q == LAST) begin
                            cnt_q   <= '0;
                            tx_q    <= 8'hFF;
                            state_q <= S_IDLE;
                        end else begin
                            cnt_q <= cnt_inc;
                            tx_q  <= rd_next;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
            if (frame_end) begin
                state_q  <= S_IDLE;
                cnt_q    <= '0;
                shadow_q <= '0;
                tx_q     <= 8'hFF;
            end
        end
    end

    assign tx_data       = tx_q;
    assign machine_start = start_q;
    assign machine_stop  = stop_q;
    assign reg_data      = reg_q;
    assign reg_update    = upd_q;
    assign cmd_err       = err_q;

endmodule

// File: tb/tb_spi_cmd_regfile.sv
// tb/tb_spi_cmd_regfile.sv - scoreboard bench for spi_cmd_regfile
module tb_spi_cmd_regfile;

    localparam int K_START = 0;
    localparam int K_STOP  = 1;
    localparam int K_UPD   = 2;
    localparam int K_ERR   = 3;
    localparam int K_TX    = 4;

    typedef struct {
        int          kind;
        logic [3:0]  mask;
        logic [63:0] data;
        int          cyc;
    } ev_t;

    logic        clk;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        cs_n;
    logic [7:0]  tx_data;
    logic        machine_start;
    logic        machine_stop;
    logic [63:0] reg_data;
    logic [3:0]  reg_update;
    logic [31:0] fb_data;
    logic        cmd_err;

    ev_t         exp_q[$];
    logic [63:0] exp_bank;
    int          total;
    int          bad;
    int          mcyc;
    int          last_cyc;
    logic [7:0]  prev_tx;

    spi_cmd_regfile dut (
        .clk           (clk),
        .rst           (rst),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .cs_n          (cs_n),
        .tx_data       (tx_data),
        .machine_start (machine_start),
        .machine_stop  (machine_stop),
        .reg_data      (reg_data),
        .reg_update    (reg_update),
        .fb_data       (fb_data),
        .cmd_err       (cmd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        #1;
        rx_data  = b;
        rx_valid = 1'b1;
        last_cyc = mcyc;
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
            rx_valid = 1'b0;
        end
    endtask

    task automatic expect_ev(input int k, input logic [3:0] m, input logic [63:0] d);
        ev_t e;
        e.kind = k;
        e.mask = m;
        e.data = d;
        e.cyc  = last_cyc + 1;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic observe(input int k, input logic [3:0] m, input logic [63:0] d);
        ev_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL ev_unexpected: got kind=%0d mask=%b data=%h cyc=%0d want none", k, m, d, mcyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.mask !== m || e.data !== d || e.cyc != mcyc) begin
                bad++;
                $display("FAIL ev: got kind=%0d mask=%b data=%h cyc=%0d want kind=%0d mask=%b data=%h cyc=%0d",
                         k, m, d, mcyc, e.kind, e.mask, e.data, e.cyc);
            end
        end
    endtask

    // Monitor: every visible output event is popped against the scoreboard
    initial begin
        mcyc    = 0;
        prev_tx = 8'hFF;
        forever begin
            @(negedge clk);
            mcyc++;
            if (!rst) begin
                if (machine_start)     observe(K_START, 4'b0, reg_data);
                if (machine_stop)      observe(K_STOP, 4'b0, reg_data);
                if (reg_update != 4'b0) observe(K_UPD, reg_update, reg_data);
                if (cmd_err)           observe(K_ERR, 4'b0, reg_data);
                if (tx_data !== prev_tx) begin
                    observe(K_TX, 4'b0, {56'h0, tx_data});
                    prev_tx = tx_data;
                end
            end
        end
    end

    initial begin
        total    = 0;
        bad      = 0;
        last_cyc = 0;
        exp_bank = 64'h0;
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        cs_n     = 1'b1;
        fb_data  = {16'hBEEF, 16'hCAFE};

        repeat (3) @(negedge clk);
        #2;
        chk("reset_reg_data", reg_data, 64'h0);
        chk("reset_tx_data", {56'h0, tx_data}, 64'hFF);
        chk("reset_pulses", {60'h0, machine_start, machine_stop, cmd_err, |reg_update}, 64'h0);
        rst  = 1'b0;
        cs_n = 1'b0;
        gap(4);

        // start / stop pulses
        send(8'h06); expect_ev(K_START, 4'b0, exp_bank);
        gap(1);
        send(8'h04); expect_ev(K_STOP, 4'b0, exp_bank);
        gap(2);

        // write reg1 with good checksum (81^34^12 = A7)
        send(8'h81); send(8'h34); send(8'h12); send(8'hA7);
        exp_bank[31:16] = 16'h1234;
        expect_ev(K_UPD, 4'b0010, exp_bank);
        gap(2);

        // write reg1 with bad checksum
        send(8'h81); send(8'h34); send(8'h12); send(8'h00);
        expect_ev(K_ERR, 4'b0, exp_bank);
        gap(2);

        // read ch1, feedback changes mid-read
        send(8'hC1); expect_ev(K_TX, 4'b0, 64'hEF);
        send(8'h00); expect_ev(K_TX, 4'b0, 64'hBE);
        gap(1);
        fb_data[31:16] = 16'h1111;
        send(8'h00); expect_ev(K_TX, 4'b0, 64'hFF);
        gap(2);

        // read ch0
        send(8'hC0); expect_ev(K_TX, 4'b0, 64'hFE);
        send(8'h00); expect_ev(K_TX, 4'b0, 64'hCA);
        send(8'h00); expect_ev(K_TX, 4'b0, 64'hFF);
        gap(2);

        // chip-select abort in the middle of a write to reg2
        send(8'h82); send(8'h55);
        gap(1);
        cs_n = 1'b1;
        gap(5);
        chk("abort_bank", reg_data, exp_bank);
        cs_n = 1'b0;
        gap(4);
        send(8'h06); expect_ev(K_START, 4'b0, exp_bank);
        gap(2);

        // illegal opcodes
        send(8'h84); expect_ev(K_ERR, 4'b0, exp_bank);
        send(8'h33); expect_ev(K_ERR, 4'b0, exp_bank);
        gap(2);

        // write reg3 (83^AA^55 = 7C) followed back-to-back by a start opcode
        send(8'h83); send(8'hAA); send(8'h55); send(8'h7C);
        exp_bank[63:48] = 16'h55AA;
        expect_ev(K_UPD, 4'b1000, exp_bank);
        send(8'h06); expect_ev(K_START, 4'b0, exp_bank);
        gap(3);

        // asynchronous reset in the middle of a write
        send(8'h81); send(8'h77);
        gap(1);
        @(negedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_reg_data", reg_data, 64'h0);
        chk("async_rst_tx_data", {56'h0, tx_data}, 64'hFF);
        chk("async_rst_pulses", {60'h0, machine_start, machine_stop, cmd_err, |reg_update}, 64'h0);
        exp_bank = 64'h0;
        @(negedge clk);
        #1;
        rst = 1'b0;
        gap(2);
        send(8'h06); expect_ev(K_START, 4'b0, exp_bank);
        gap(4);

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL ev_missing: got %0d events still pending want 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_cmd_regfile.md
Name: spi_cmd_regfile

Overview:
- Parametrised byte-level command decoder for the SPI slave path.
- Consumes the received-byte stream from spi_slave_driver and decodes one-byte opcodes:
  - start/stop pulses
  - multi-byte writes into NUM_REGS parameter registers
  - multi-byte reads from NUM_FB feedback channels
- Supplies the response byte back to the driver.
- Adds DATA_W-generic widths, optional XOR checksum, atomic register commit and chip-select abort.

Parameters:
- NUM_REGS, 4, number of writable parameter registers (1..16).
- NUM_FB, 2, number of readable feedback channels (1..16).
- DATA_W, 16, register/feedback width in bits; a multiple of 8, maximum 64. NB = DATA_W/8.
- CHK_EN, 1, 1 = write commands carry a trailing checksum byte; 0 = no checksum byte.
- REG_RST, 0, reset value of every parameter register.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- rx_data  in  8  byte received from SPI driver.
- rx_valid  in  1  one-cycle strobe, rx_data valid.
- cs_n  in  1  raw SPI chip select, asynchronous to clk.
- tx_data  out  8  response byte for the driver's next transfer.
- machine_start  out  1  one-cycle pulse.
- machine_stop  out  1  one-cycle pulse.
- reg_data  out  NUM_REGS*DATA_W  flat register bank; reg n at [n*DATA_W +: DATA_W].
- reg_update  out  NUM_REGS  one-cycle pulse per committed register.
- fb_data  in  NUM_FB*DATA_W  flat feedback bank, same packing.
- cmd_err  out  1  one-cycle pulse on a checksum mismatch or an illegal opcode.

Behaviour:

Reset (asynchronous, rst=1):
- state=IDLE; reg_data = REG_RST replicated; tx_data=8'hFF.
- All pulses 0; byte counter 0; shadow buffers 0.

cs_n handling:
- cs_n passes through a 2-flop synchroniser.
- A synchronised rising edge (frame end) forces IDLE in the next cycle from any state.
- On that abort: partial write data is discarded; no reg_update, no cmd_err; tx_data=8'hFF.
- If frame end and rx_valid occur in the same cycle, the byte is processed first, then the abort applies.

Opcode decoding in IDLE (on rx_valid):
- 8'h06 -> PULSE_START: machine_start=1 for exactly one cycle, asserted in the cycle after rx_valid, then IDLE.
- 8'h04 -> PULSE_STOP: same, driving machine_stop.
- 8'h80|n, n<NUM_REGS -> WR_DATA: cnt=0, checksum accumulator = opcode.
- 8'hC0|n, n<NUM_FB -> RD_DATA: fb channel n snapshotted into shadow in that same cycle; tx_data = shadow byte 0 in the next cycle.
- Any other byte, including an out-of-range n -> cmd_err pulse, stay IDLE.

WR_DATA:
- Each rx_valid stores the byte into shadow[cnt*8 +: 8] (LSB first), XORs it into the accumulator, and increments cnt.
- After byte NB-1: go to WR_CHK if CHK_EN, otherwise commit.

WR_CHK:
- Next rx_valid: if byte == accumulator, commit; otherwise cmd_err pulse and shadow discarded. Either way, go to IDLE.

Commit:
- reg n = shadow, all DATA_W bits updated in one cycle (consumers never see a half-written value).
- reg_update[n] pulses the cycle after the final byte's rx_valid.

RD_DATA:
- Each rx_valid advances cnt; tx_data = shadow byte cnt.
- After byte NB-1 has been presented and its rx_valid is received: tx_data=8'hFF, go to IDLE.
- The snapshot is not refreshed mid-read.

General rules:
- tx_data is 8'hFF in every state other than RD_DATA.
- rx_valid is ignored in PULSE states (one cycle only).
- Back-to-back commands with no idle cycle between the last byte and the next opcode are supported: IDLE accepts an opcode in the cycle it is entered.
- cnt width = clog2(NB)+1; cnt never wraps within a command.

Test Plan:
- Reset then bytes 06, 04 -> machine_start one pulse one cycle after the first rx_valid, then machine_stop one pulse; reg_data=0, tx_data=FF.
- DATA_W=16, CHK_EN=1: bytes 81,34,12,A7 (81^34^12) -> reg1=16'h1234, reg_update=4'b0010 one cycle; bytes 81,34,12,00 -> cmd_err pulse, reg1 unchanged.
- fb ch1=16'hBEEF, bytes C1,xx,xx -> tx_data EF after C1, BE after the next byte, FF after the last; fb changing mid-read does not alter the bytes.
- Bytes 82,55 then cs_n rises -> IDLE, reg2 unchanged, no reg_update; next frame 06 -> machine_start pulse.
- Bytes 84 (NUM_REGS=4) and 33 -> cmd_err pulse each, state stays IDLE, no register change.
- Assert rst mid-WR_DATA -> all outputs at reset values immediately, before the next clk edge.
